// File: rtl/secded_pkg.sv
// ----------------------------------------------------------------------------
// secded_pkg
// Shared constants and types for the SECDED request arbiter.
//   NREQ            : number of requesters (fixed at 8)
//   IDW             : width of a requester index
//   TIMEOUT_CYC_DEF : default watchdog limit in WAIT cycles
//   state_t         : sequencer states
// ----------------------------------------------------------------------------
package secded_pkg;

    localparam int NREQ            = 8;
    localparam int IDW             = 3;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/secded_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// secded_req_arbiter_if
// Bundle of the requester and shared-unit handshake signals.
//   req      : request vector, bit i = requester i wants the unit
//   done     : single-cycle completion pulse from the shared unit
//   start    : single-cycle start pulse to the shared unit
//   grant    : one-hot grant (or zero)
//   grant_id : binary index of the granted requester (datapath mux select)
//   busy     : an operation is in flight
//   timeout  : single-cycle abort pulse from the watchdog
// Modports:
//   master : drives req/done, observes the arbiter outputs
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface secded_req_arbiter_if;

    logic [secded_pkg::NREQ-1:0] req;
    logic                        done;
    logic                        start;
    logic [secded_pkg::NREQ-1:0] grant;
    logic [secded_pkg::IDW-1:0]  grant_id;
    logic                        busy;
    logic                        timeout;

    modport master (
        output req,
        output done,
        input  start,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output start,
        output grant,
        output grant_id,
        output busy,
        output timeout
    );

endinterface

// File: rtl/arb_prio_enc.sv
// ----------------------------------------------------------------------------
// arb_prio_enc
// Combinational 8-to-3 priority encoder, highest set index wins.
//   vec   : input vector
//   idx   : index of the highest set bit (0 when vec is all-zero)
//   valid : vec has at least one bit set
// ----------------------------------------------------------------------------
module arb_prio_enc
    import secded_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    output logic [IDW-1:0]  idx,
    output logic            valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < NREQ; i++) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/secded_req_arbiter.sv
// ----------------------------------------------------------------------------
// secded_req_arbiter
// Round-robin arbiter/sequencer sharing one SECDED encode/decode unit among
// 8 requesters. A pick is made in IDLE, a single start pulse is issued in
// ISSUE, and the grant is held through WAIT until the unit reports done.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : secded_req_arbiter_if.slave (req, done in; start, grant,
//         grant_id, busy, timeout out)
//
// Parameter:
//   TIMEOUT_CYC : WAIT cycles allowed before abort (1..255), watchdog only
//
// Build option:
//   SECDED_ARB_WATCHDOG_EN : when defined, an 8-bit WAIT counter aborts an
//   operation after TIMEOUT_CYC cycles without done and pulses timeout.
//   When undefined, timeout is constant 0 and WAIT blocks until done.
// ----------------------------------------------------------------------------
module secded_req_arbiter
    import secded_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    secded_req_arbiter_if.slave  bus
);

    state_t            state_reg;
    logic              start_reg;
    logic              busy_reg;
    logic [NREQ-1:0]   grant_reg;
    logic [IDW-1:0]    grant_id_reg;
    logic [IDW-1:0]    last_reg;

    // Rotating mask: only requesters strictly below the last winner.
    // last=0 yields an empty mask, so the unmasked pick takes over.
    logic [NREQ-1:0]   mask;
    logic [NREQ-1:0]   req_masked;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign mask[gi] = (IDW'(gi) < last_reg);
    end

    assign req_masked = bus.req & mask;

    logic [IDW-1:0]    masked_idx;
    logic              masked_valid;
    logic [IDW-1:0]    full_idx;
    logic              full_valid;
    logic [IDW-1:0]    pick;

    arb_prio_enc u_enc_masked (
        .vec   (req_masked),
        .idx   (masked_idx),
        .valid (masked_valid)
    );

    arb_prio_enc u_enc_full (
        .vec   (bus.req),
        .idx   (full_idx),
        .valid (full_valid)
    );

    assign pick = masked_valid ? masked_idx : full_idx;

`ifdef SECDED_ARB_WATCHDOG_EN
    logic [7:0] wd_cnt_reg;
    logic       timeout_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            last_reg     <= '0;
`ifdef SECDED_ARB_WATCHDOG_EN
            wd_cnt_reg   <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            // start and timeout are single-cycle pulses by default.
            start_reg <= 1'b0;
`ifdef SECDED_ARB_WATCHDOG_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    // full_valid is equivalent to |req here.
                    if (full_valid) begin
                        grant_reg    <= NREQ'(1) << pick;
                        grant_id_reg <= pick;
                        last_reg     <= pick;
                        start_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= ISSUE;
`ifdef SECDED_ARB_WATCHDOG_EN
                        wd_cnt_reg   <= '0;
`endif
                    end
                end

                ISSUE: begin
                    if (bus.done) begin
                        // Zero-latency unit: completion seen with start.
                        grant_reg    <= '0;
                        grant_id_reg <= '0;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        state_reg    <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.done) begin
                        grant_reg    <= '0;
                        grant_id_reg <= '0;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
`ifdef SECDED_ARB_WATCHDOG_EN
                    end else if (wd_cnt_reg == 8'(TIMEOUT_CYC - 1)) begin
                        // Expiry: abort; last_reg is kept so the hung
                        // requester is rotated past on the next pick.
                        grant_reg    <= '0;
                        grant_id_reg <= '0;
                        busy_reg     <= 1'b0;
                        timeout_reg  <= 1'b1;
                        state_reg    <= IDLE;
                    end else begin
                        wd_cnt_reg   <= wd_cnt_reg + 8'd1;
`endif
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    grant_reg    <= '0;
                    grant_id_reg <= '0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start    = start_reg;
    assign bus.busy     = busy_reg;
    assign bus.grant    = grant_reg;
    assign bus.grant_id = grant_id_reg;

`ifdef SECDED_ARB_WATCHDOG_EN
    assign bus.timeout  = timeout_reg;
`else
    // No watchdog: for any legal TIMEOUT_CYC (1..255) this is constant 0.
    assign bus.timeout  = (TIMEOUT_CYC < 1);
`endif

endmodule
